xphy_link_seq: RTL and testbench

XPHY_LINK_SEQ -- requirements
Module: xphy_link_seq

---
 rtl/xphy_link_seq.sv | 148 ++++++++++++++
 tb/tb_xphy_link_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xphy_link_seq.sv
// rtl/xphy_link_seq.sv - per-port 10G PHY bring-up sequencer: sync, reset FSM, link debounce
// Optional macro XPHY_LINK_SEQ_STATS_EN adds per-port 16-bit link_drops counters.
module xphy_link_seq #(
   parameter int         C_NUM_PORTS      = 1,
   parameter int         C_HOLD_CYCLES    = 16,
   parameter int         C_LINK_DEBOUNCE  = 1024,
   parameter logic [4:0] C_MDIO_ADDR_BASE = 5'h0
) (
   input  logic                     clk156,
   input  logic                     reset,
   input  logic [C_NUM_PORTS-1:0]   tx_resetdone,
   input  logic [C_NUM_PORTS-1:0]   rx_resetdone,
   input  logic [C_NUM_PORTS-1:0]   tx_fault,
   input  logic [C_NUM_PORTS-1:0]   signal_detect,
   input  logic [8*C_NUM_PORTS-1:0] core_status,
   output logic [C_NUM_PORTS-1:0]   core_reset_tx,
   output logic [C_NUM_PORTS-1:0]   core_reset_rx,
   output logic [C_NUM_PORTS-1:0]   axis_aresetn,
   output logic [C_NUM_PORTS-1:0]   linkup,
   output logic [5*C_NUM_PORTS-1:0] prtad,
   output logic [C_NUM_PORTS-1:0]   sfp_rs
`ifdef XPHY_LINK_SEQ_STATS_EN
   ,
   output logic [16*C_NUM_PORTS-1:0] link_drops
`endif
);

   localparam int          LP_NB     = 4 * C_NUM_PORTS;
   localparam logic [15:0] LP_HOLD_TC = 16'(C_HOLD_CYCLES - 1);
   localparam logic [15:0] LP_DEB_MAX = 16'(C_LINK_DEBOUNCE);

   typedef enum logic [1:0] {
      ST_RST  = 2'b00,
      ST_HOLD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   logic [LP_NB-1:0] w_async;
   (* async_reg = "true" *) logic [LP_NB-1:0] r_sync1;
   (* async_reg = "true" *) logic [LP_NB-1:0] r_sync2;

   assign w_async = {signal_detect, tx_fault, rx_resetdone, tx_resetdone};

   always_ff @(posedge clk156 or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_async;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_port
      logic        w_txd, w_rxd, w_flt, w_sd, w_ok, w_status, w_deb_run, w_linkup_nxt;
      logic        w_unused_status;
      state_t      r_state;
      logic [15:0] r_hold_cnt;
      logic [15:0] r_deb_cnt;
      logic        r_core_rst;
      logic        r_linkup;

      assign w_txd           = r_sync2[gi];
      assign w_rxd           = r_sync2[C_NUM_PORTS + gi];
      assign w_flt           = r_sync2[2*C_NUM_PORTS + gi];
      assign w_sd            = r_sync2[3*C_NUM_PORTS + gi];
      assign w_ok            = w_txd & w_rxd & ~w_flt & w_sd;
      assign w_status        = core_status[8*gi];
      assign w_unused_status = ^core_status[8*gi+1 +: 7];

      // Core reset is registered alongside the state so it never sees input glitches.
      always_ff @(posedge clk156 or posedge reset) begin
         if (reset) begin
            r_state    <= ST_RST;
            r_hold_cnt <= '0;
            r_core_rst <= 1'b1;
         end else begin
            case (r_state)
               ST_RST: begin
                  r_core_rst <= 1'b1;
                  if (w_ok) begin
                     r_state    <= ST_HOLD;
                     r_hold_cnt <= '0;
                  end
               end
               ST_HOLD: begin
                  if (!w_ok) begin
                     r_state    <= ST_RST;
                     r_core_rst <= 1'b1;
                  end else if (r_hold_cnt == LP_HOLD_TC) begin
                     r_state    <= ST_RUN;
                     r_core_rst <= 1'b0;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + 16'd1;
                  end
               end
               ST_RUN: begin
                  if (!w_ok) begin
                     r_state    <= ST_RST;
                     r_core_rst <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_RST;
                  r_core_rst <= 1'b1;
               end
            endcase
         end
      end

      assign w_deb_run    = (r_state == ST_RUN) && w_status;
      assign w_linkup_nxt = w_deb_run && (r_deb_cnt == LP_DEB_MAX);

      always_ff @(posedge clk156 or posedge reset) begin
         if (reset) begin
            r_deb_cnt <= '0;
            r_linkup  <= 1'b0;
         end else begin
            if (!w_deb_run)
               r_deb_cnt <= '0;
            else if (r_deb_cnt != LP_DEB_MAX)
               r_deb_cnt <= r_deb_cnt + 16'd1;
            r_linkup <= w_linkup_nxt;
         end
      end

`ifdef XPHY_LINK_SEQ_STATS_EN
      logic [15:0] r_drops;

      always_ff @(posedge clk156 or posedge reset) begin
         if (reset)
            r_drops <= '0;
         else if (r_linkup && !w_linkup_nxt && r_drops != 16'hFFFF)
            r_drops <= r_drops + 16'd1;
      end

      assign link_drops[16*gi +: 16] = r_drops;
`endif

      assign core_reset_tx[gi]  = r_core_rst;
      assign core_reset_rx[gi]  = r_core_rst;
      assign axis_aresetn[gi]   = w_txd & w_rxd;
      assign linkup[gi]         = r_linkup;
      assign prtad[5*gi +: 5]   = C_MDIO_ADDR_BASE + 5'(gi);
      assign sfp_rs[gi]         = 1'b1;
   end

endmodule

// File: tb/tb_xphy_link_seq.sv
// tb/tb_xphy_link_seq.sv - directed self-checking bench for xphy_link_seq (2 ports, HOLD=16, DEBOUNCE=8)
module tb_xphy_link_seq;

   localparam int N    = 2;
   localparam int HOLD = 16;
   localparam int DEB  = 8;

   logic           clk156 = 1'b0;
   logic           reset;
   logic [N-1:0]   tx_resetdone, rx_resetdone, tx_fault, signal_detect;
   logic [8*N-1:0] core_status;
   logic [N-1:0]   core_reset_tx, core_reset_rx, axis_aresetn, linkup, sfp_rs;
   logic [5*N-1:0] prtad;
`ifdef XPHY_LINK_SEQ_STATS_EN
   logic [16*N-1:0] link_drops;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk156 = ~clk156;

   xphy_link_seq #(
      .C_NUM_PORTS      (N),
      .C_HOLD_CYCLES    (HOLD),
      .C_LINK_DEBOUNCE  (DEB),
      .C_MDIO_ADDR_BASE (5'h0)
   ) dut (
      .clk156        (clk156),
      .reset         (reset),
      .tx_resetdone  (tx_resetdone),
      .rx_resetdone  (rx_resetdone),
      .tx_fault      (tx_fault),
      .signal_detect (signal_detect),
      .core_status   (core_status),
      .core_reset_tx (core_reset_tx),
      .core_reset_rx (core_reset_rx),
      .axis_aresetn  (axis_aresetn),
      .linkup        (linkup),
      .prtad         (prtad),
      .sfp_rs        (sfp_rs)
`ifdef XPHY_LINK_SEQ_STATS_EN
      ,
      .link_drops    (link_drops)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk156);
   endtask

   initial begin
      reset         = 1'b1;
      tx_resetdone  = 2'b11;
      rx_resetdone  = 2'b11;
      tx_fault      = 2'b00;
      signal_detect = 2'b11;
      core_status   = 16'h0101;
      step(3);
      check("rst_core_reset_tx", 32'(core_reset_tx), 32'h3);
      check("rst_core_reset_rx", 32'(core_reset_rx), 32'h3);
      check("rst_axis", 32'(axis_aresetn), 32'h0);
      check("rst_linkup", 32'(linkup), 32'h0);
      check("prtad", 32'(prtad), 32'h020);
      check("sfp_rs", 32'(sfp_rs), 32'h3);
`ifdef XPHY_LINK_SEQ_STATS_EN
      check("rst_drops", link_drops, 32'h0);
`endif

      // Reset release at a negedge; following posedges are numbered 1, 2, ...
      reset = 1'b0;
      step(1);
      check("axis_e1", 32'(axis_aresetn), 32'h0);
      step(1);
      check("axis_e2", 32'(axis_aresetn), 32'h3);
      step(16);
      check("core_rst_e18", 32'(core_reset_tx), 32'h3);
      step(1);
      check("core_rst_e19", 32'(core_reset_tx), 32'h0);
      check("core_rst_rx_e19", 32'(core_reset_rx), 32'h0);
      step(8);
      check("linkup_e27", 32'(linkup), 32'h0);
      step(1);
      check("linkup_e28", 32'(linkup), 32'h3);

      // One-cycle tx_fault on port 0 while in RUN
      step(2);
      tx_fault = 2'b01;
      step(1);
      tx_fault = 2'b00;
      step(1);
      check("fault_k2_core_rst", 32'(core_reset_tx), 32'h0);
      step(1);
      check("fault_k3_core_rst_tx", 32'(core_reset_tx), 32'h1);
      check("fault_k3_core_rst_rx", 32'(core_reset_rx), 32'h1);
      step(1);
      check("fault_k4_linkup", 32'(linkup), 32'h2);
      check("fault_k4_axis", 32'(axis_aresetn), 32'h3);
      step(15);
      check("fault_hold_end", 32'(core_reset_tx), 32'h1);
      step(1);
      check("fault_run_again", 32'(core_reset_tx), 32'h0);
      step(9);
      check("fault_linkup_back", 32'(linkup), 32'h3);

      // Debounce: a 5-cycle status burst is too short, a 9-cycle run qualifies
      core_status = 16'h0100;
      step(1);
      check("status_fall_linkup", 32'(linkup), 32'h2);
      core_status = 16'h0101;
      step(5);
      core_status = 16'h0100;
      check("deb_5_high", 32'(linkup), 32'h2);
      step(1);
      check("deb_after_glitch", 32'(linkup), 32'h2);
      step(1);
      core_status = 16'h0101;
      step(8);
      check("deb_8_steady", 32'(linkup), 32'h2);
      step(1);
      check("deb_9_steady", 32'(linkup), 32'h3);

      // Port independence: signal_detect lost on port 1 only
      signal_detect = 2'b01;
      step(3);
      check("p1_sd_core_rst_tx", 32'(core_reset_tx), 32'h2);
      check("p1_sd_core_rst_rx", 32'(core_reset_rx), 32'h2);
      step(1);
      check("p1_sd_linkup", 32'(linkup), 32'h1);
      signal_detect = 2'b11;
      step(18);
      check("p1_hold_end", 32'(core_reset_tx), 32'h2);
      step(1);
      check("p1_run_again", 32'(core_reset_tx), 32'h0);
      step(9);
      check("p1_linkup_back", 32'(linkup), 32'h3);

`ifdef XPHY_LINK_SEQ_STATS_EN
      check("drops_pre", link_drops, {16'd1, 16'd2});
      core_status = 16'h0100;
      step(1);
      check("drops_three", link_drops, {16'd1, 16'd3});
      core_status = 16'h0101;
      step(9);
      check("drops_linkup_back", 32'(linkup), 32'h3);
      force dut.g_port[0].r_drops = 16'hFFFF;
      #1;
      release dut.g_port[0].r_drops;
      core_status = 16'h0100;
      step(1);
      check("drops_saturate", link_drops, {16'd1, 16'hFFFF});
      core_status = 16'h0101;
      step(9);
`endif

      // Asynchronous reset while in RUN
      #2;
      reset = 1'b1;
      #1;
      check("arst_run_core_rst", 32'(core_reset_tx), 32'h3);
      check("arst_run_linkup", 32'(linkup), 32'h0);
      check("arst_run_axis", 32'(axis_aresetn), 32'h0);
`ifdef XPHY_LINK_SEQ_STATS_EN
      check("arst_run_drops", link_drops, 32'h0);
`endif
      step(1);
      reset = 1'b0;
      step(10);
      // Hold counter is 7 here; reset again between edges
      #2;
      reset = 1'b1;
      #1;
      check("arst_hold_core_rst", 32'(core_reset_rx), 32'h3);
      check("arst_hold_axis", 32'(axis_aresetn), 32'h0);
      step(1);
      reset = 1'b0;
      step(18);
      check("restart_e18", 32'(core_reset_tx), 32'h3);
      step(1);
      check("restart_e19", 32'(core_reset_tx), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
